// File: rtl/rng_request_scheduler_if.sv
// Requester/RNG-facing bundle of the RNG request scheduler.
// The scheduler takes the slave view; requesters and the RNG drive the master view.
interface rng_request_scheduler_if #(
   parameter int NREQ   = 4,
   parameter int RAND_W = 7
);
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   gnt;
   logic              rnd_valid;
   logic [RAND_W-1:0] rnd_data;
   logic              rnd_err;
   logic              rng_send;
   logic [RAND_W-1:0] rng_rand;

   modport master (output req, ack, rng_rand,
                   input  gnt, rnd_valid, rnd_data, rnd_err, rng_send);
   modport slave  (input  req, ack, rng_rand,
                   output gnt, rnd_valid, rnd_data, rnd_err, rng_send);
endinterface

// File: rtl/rng_request_scheduler.sv
// Round-robin sharing of one RNG between NREQ requesters, with optional rejection
// sampling into [1, LIMIT-1] when RNG_SCHED_REJECT_EN is defined.
module rng_request_scheduler #(
   parameter int NREQ      = 4,
   parameter int RAND_W    = 7,
   parameter int SETTLE    = 2,
   parameter int LIMIT     = 97,
   parameter int MAX_RETRY = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   rng_request_scheduler_if.slave bus
);
   localparam int PW = (NREQ > 1)   ? $clog2(NREQ)   : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {IDLE, FIRE, WAIT, CHECK, DELIVER} state_t;

   state_t            state;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     gidx;
   logic [PW-1:0]     arb_idx;
   logic [PW-1:0]     cand;
   logic              arb_hit;
   logic [SW-1:0]     settle_cnt;
   logic [RAND_W-1:0] sample;
   logic [NREQ-1:0]   gnt;
   logic              rnd_valid;
   logic [RAND_W-1:0] rnd_data;
   logic              rng_send;
   logic              req_g;
   logic              ack_g;
   logic              abandon;

   // Configurations outside the legal range elaborate nothing extra here.
   if (NREQ < 2 || SETTLE < 1 || LIMIT < 2 || MAX_RETRY < 1) begin : g_param_range
   end

   // Scan downward in offset so the lowest offset from rr_ptr wins.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      cand    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = PW'((int'(rr_ptr) + i) % NREQ);
         if (bus.req[cand]) begin
            arb_hit = 1'b1;
            arb_idx = cand;
         end
      end
   end

   assign req_g   = bus.req[gidx];
   assign ack_g   = bus.ack[gidx] & gnt[gidx];
   // A drop coinciding with the acknowledging edge is a completion, not an abandon.
   assign abandon = (state != IDLE) && !req_g && !((state == DELIVER) && ack_g);

`ifdef RNG_SCHED_REJECT_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0] retry_cnt;
   logic          rnd_err_q;
   logic          accept;

   assign accept      = (sample != '0) && (sample <= RAND_W'(LIMIT - 1));
   assign bus.rnd_err = rnd_err_q;
`else
   assign bus.rnd_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         gidx       <= '0;
         gnt        <= '0;
         rnd_valid  <= 1'b0;
         rnd_data   <= '0;
         rng_send   <= 1'b0;
         settle_cnt <= '0;
         sample     <= '0;
`ifdef RNG_SCHED_REJECT_EN
         retry_cnt  <= '0;
         rnd_err_q  <= 1'b0;
`endif
      end else if (abandon) begin
         state     <= IDLE;
         gnt       <= '0;
         rnd_valid <= 1'b0;
         rng_send  <= 1'b0;
`ifdef RNG_SCHED_REJECT_EN
         retry_cnt <= '0;
         rnd_err_q <= 1'b0;
`endif
      end else begin
         rng_send <= 1'b0;
         case (state)
            IDLE: if (arb_hit) begin
               gidx     <= arb_idx;
               gnt      <= NREQ'(1) << arb_idx;
               rng_send <= 1'b1;
               state    <= FIRE;
            end
            FIRE: begin
               settle_cnt <= SW'(SETTLE - 1);
               state      <= WAIT;
            end
            WAIT: begin
               if (settle_cnt == '0) begin
                  sample <= bus.rng_rand;
                  state  <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            CHECK: begin
`ifdef RNG_SCHED_REJECT_EN
               if (accept) begin
                  rnd_data  <= sample;
                  retry_cnt <= '0;
                  rnd_valid <= 1'b1;
                  state     <= DELIVER;
               end else if (retry_cnt != RW'(MAX_RETRY)) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  rng_send  <= 1'b1;
                  state     <= FIRE;
               end else begin
                  rnd_data  <= '0;
                  rnd_err_q <= 1'b1;
                  retry_cnt <= '0;
                  rnd_valid <= 1'b1;
                  state     <= DELIVER;
               end
`else
               rnd_data  <= sample;
               rnd_valid <= 1'b1;
               state     <= DELIVER;
`endif
            end
            DELIVER: if (ack_g) begin
               rnd_valid <= 1'b0;
               gnt       <= '0;
               rr_ptr    <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
`ifdef RNG_SCHED_REJECT_EN
               rnd_err_q <= 1'b0;
`endif
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt;
   assign bus.rnd_valid = rnd_valid;
   assign bus.rnd_data  = rnd_data;
   assign bus.rng_send  = rng_send;
endmodule

// File: tb/tb_rng_request_scheduler.sv
// Self-checking bench for rng_request_scheduler: RNG model plus a transaction-level
// reference (round-robin pick, accept rule, pulse count, latency) built from plain arithmetic.
module tb_rng_request_scheduler;
   localparam int NREQ      = 4;
   localparam int RAND_W    = 7;
   localparam int SETTLE    = 2;
   localparam int LIMIT     = 97;
   localparam int MAX_RETRY = 15;
`ifdef RNG_SCHED_REJECT_EN
   localparam bit REJ = 1'b1;
`else
   localparam bit REJ = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_ptr = 0;
   int   pulse_cnt = 0;
   logic [RAND_W-1:0] rng_q[$];

   rng_request_scheduler_if #(.NREQ(NREQ), .RAND_W(RAND_W)) bus ();

   rng_request_scheduler #(.NREQ(NREQ), .RAND_W(RAND_W), .SETTLE(SETTLE),
                           .LIMIT(LIMIT), .MAX_RETRY(MAX_RETRY))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // RNG: a send pulse seen at an edge loads the next queued value.
   always @(posedge clk) begin
      if (bus.rng_send === 1'b1) begin
         pulse_cnt <= pulse_cnt + 1;
         if (rng_q.size() > 0) bus.rng_rand <= rng_q.pop_front();
         else                  bus.rng_rand <= RAND_W'($urandom);
      end
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) rng_q.push_back(RAND_W'($urandom_range(0, 127)));
   endtask

   function automatic int pick(input logic [NREQ-1:0] r);
      for (int i = 0; i < NREQ; i++)
         if (r[(exp_ptr + i) % NREQ]) return (exp_ptr + i) % NREQ;
      return -1;
   endfunction

   // Walk the queued RNG values: the first acceptable one is delivered; MAX_RETRY+1 rejects is an error.
   function automatic void model(output int pulses, output logic [RAND_W-1:0] data, output logic err);
      pulses = 0; data = '0; err = 1'b0;
      for (int k = 0; k <= MAX_RETRY; k++) begin
         pulses++;
         if (!REJ || (rng_q[k] >= 1 && rng_q[k] < LIMIT)) begin
            data = rng_q[k];
            return;
         end
      end
      err = 1'b1;
   endfunction

   task automatic apply_reset;
      rst_n = 1'b0; bus.req = '0; bus.ack = '0;
      tick; tick;
      rst_n = 1'b1; exp_ptr = 0;
   endtask

   // Starts from IDLE with bus.req already driven; queue must hold >= MAX_RETRY+1 values.
   task automatic run_txn(input string tag, input int hold, input bit finish, input bit drop_on_ack,
                          output logic [NREQ-1:0] got_gnt, output logic [RAND_W-1:0] got_data,
                          output int got_lat);
      int g, exp_pulses, p0, exp_lat;
      logic [RAND_W-1:0] exp_data;
      logic exp_err;
      logic [NREQ-1:0] exp_gnt;
      g = pick(bus.req);
      model(exp_pulses, exp_data, exp_err);
      exp_gnt = NREQ'(1) << g;
      exp_lat = 1 + exp_pulses * (SETTLE + 2);
      p0 = pulse_cnt;
      tick; got_lat = 1;
      got_gnt = bus.gnt;
      n_cmp++;
      if (bus.gnt !== exp_gnt || bus.rng_send !== 1'b1)
         $display("FAIL %s grant: got gnt=%b send=%b want gnt=%b send=1", tag, bus.gnt, bus.rng_send, exp_gnt);
      while (bus.rnd_valid !== 1'b1 && got_lat < 200) begin tick; got_lat++; end
      got_data = bus.rnd_data;
      n_cmp++;
      if (got_lat != exp_lat) begin
         n_err++; $display("FAIL %s latency: got %0d want %0d", tag, got_lat, exp_lat);
      end
      n_cmp++;
      if (bus.rnd_data !== exp_data || bus.rnd_err !== exp_err || (pulse_cnt - p0) != exp_pulses) begin
         n_err++;
         $display("FAIL %s result: got data=%0d err=%b pulses=%0d want data=%0d err=%b pulses=%0d",
                  tag, bus.rnd_data, bus.rnd_err, pulse_cnt - p0, exp_data, exp_err, exp_pulses);
      end
      if (bus.gnt !== exp_gnt) n_err++;
      if (!finish) return;
      for (int h = 0; h < hold; h++) begin
         bus.ack = NREQ'($urandom) & ~exp_gnt;
         tick;
         n_cmp++;
         if (bus.rnd_valid !== 1'b1 || bus.rnd_data !== exp_data || bus.gnt !== exp_gnt) begin
            n_err++;
            $display("FAIL %s hold: got valid=%b data=%0d gnt=%b want valid=1 data=%0d gnt=%b",
                     tag, bus.rnd_valid, bus.rnd_data, bus.gnt, exp_data, exp_gnt);
         end
      end
      bus.ack = exp_gnt;
      if (drop_on_ack) bus.req = bus.req & ~exp_gnt;
      tick;
      bus.ack = '0;
      n_cmp++;
      if (bus.rnd_valid !== 1'b0 || bus.gnt !== '0 || bus.rnd_err !== 1'b0) begin
         n_err++;
         $display("FAIL %s release: got valid=%b gnt=%b err=%b want 0 0 0", tag, bus.rnd_valid, bus.gnt, bus.rnd_err);
      end
      exp_ptr = (g + 1) % NREQ;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; bus.req = '1; bus.ack = '0;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_cmp++;
         if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0 || bus.rng_send !== 1'b0 || bus.rnd_data !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got gnt=%b valid=%b send=%b data=%0d want all 0",
                     bus.gnt, bus.rnd_valid, bus.rng_send, bus.rnd_data);
         end
      end
      rst_n = 1'b1;
      tick;
      n_cmp++;
      if (bus.gnt !== 4'b0001) begin
         n_err++; $display("FAIL reset_release: got gnt=%b want 0001", bus.gnt);
      end
      apply_reset;
   endtask

   task automatic test_single;
      logic [NREQ-1:0] gg; logic [RAND_W-1:0] dd; int lat;
      rng_q.delete(); rng_q.push_back(7'd42); fill_rand(MAX_RETRY);
      bus.req = 4'b0100;
      run_txn("single", 3, 1'b1, 1'b1, gg, dd, lat);
      n_cmp++;
      if (gg !== 4'b0100 || dd !== 7'd42 || lat != SETTLE + 3) begin
         n_err++; $display("FAIL single_fixed: got gnt=%b data=%0d lat=%0d want 0100 42 %0d", gg, dd, lat, SETTLE + 3);
      end
      bus.req = '0;
   endtask

   task automatic test_round_robin;
      logic [NREQ-1:0] seq [5];
      logic [NREQ-1:0] gg; logic [RAND_W-1:0] dd; int lat;
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      apply_reset;
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         rng_q.delete(); fill_rand(MAX_RETRY + 1);
         run_txn("round_robin", i % 2, 1'b1, 1'b0, gg, dd, lat);
         n_cmp++;
         if (gg !== seq[i]) begin
            n_err++; $display("FAIL rr_seq[%0d]: got %b want %b", i, gg, seq[i]);
         end
      end
      bus.req = '0;
   endtask

   task automatic test_reject;
      logic [NREQ-1:0] gg; logic [RAND_W-1:0] dd; int lat;
      rng_q.delete();
      rng_q.push_back(7'd0); rng_q.push_back(7'd120); rng_q.push_back(7'd97); rng_q.push_back(7'd5);
      fill_rand(MAX_RETRY);
      bus.req = 4'b0001;
      run_txn("reject", 1, 1'b1, 1'b1, gg, dd, lat);
      n_cmp++;
      if (dd !== (REJ ? 7'd5 : 7'd0)) begin
         n_err++; $display("FAIL reject_value: got %0d want %0d", dd, REJ ? 5 : 0);
      end
      bus.req = '0;
   endtask

   task automatic test_exhaustion;
      logic [NREQ-1:0] gg; logic [RAND_W-1:0] dd; int lat;
      int p0;
      rng_q.delete();
      for (int i = 0; i < MAX_RETRY + 4; i++) rng_q.push_back('0);
      bus.req = 4'b1000;
      p0 = pulse_cnt;
      run_txn("exhaust", 0, 1'b0, 1'b0, gg, dd, lat);
      n_cmp++;
      if (bus.rnd_err !== REJ || dd !== '0 || (pulse_cnt - p0) != (REJ ? MAX_RETRY + 1 : 1)) begin
         n_err++;
         $display("FAIL exhaust_fixed: got err=%b data=%0d pulses=%0d want err=%b data=0 pulses=%0d",
                  bus.rnd_err, dd, pulse_cnt - p0, REJ, REJ ? MAX_RETRY + 1 : 1);
      end
      bus.ack = gg; bus.req = '0;
      tick;
      bus.ack = '0;
      exp_ptr = 0;
   endtask

   task automatic test_abandon;
      logic [NREQ-1:0] gg; logic [RAND_W-1:0] dd; int lat;
      int p0;
      apply_reset;
      rng_q.delete(); fill_rand(MAX_RETRY + 1);
      bus.req = 4'b0001;
      run_txn("abandon_pre", 0, 1'b1, 1'b1, gg, dd, lat);
      rng_q.delete(); fill_rand(MAX_RETRY + 1);
      bus.req = 4'b0010;
      tick; tick;
      bus.req = '0;
      tick;
      n_cmp++;
      if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0) begin
         n_err++; $display("FAIL abandon_idle: got gnt=%b valid=%b want 0 0", bus.gnt, bus.rnd_valid);
      end
      p0 = pulse_cnt;
      tick; tick;
      n_cmp++;
      if (pulse_cnt != p0 || bus.rng_send !== 1'b0) begin
         n_err++; $display("FAIL abandon_quiet: got pulses=%0d want 0", pulse_cnt - p0);
      end
      rng_q.delete(); fill_rand(MAX_RETRY + 1);
      bus.req = 4'b1111;
      run_txn("abandon_regrant", 0, 1'b1, 1'b1, gg, dd, lat);
      n_cmp++;
      if (gg !== 4'b0010) begin
         n_err++; $display("FAIL abandon_regrant_fixed: got %b want 0010", gg);
      end
      bus.req = '0;
   endtask

   task automatic test_reset_mid;
      logic [NREQ-1:0] gg; logic [RAND_W-1:0] dd; int lat;
      rng_q.delete(); fill_rand(MAX_RETRY + 1);
      bus.req = 4'b0100;
      run_txn("mid_reset", 0, 1'b0, 1'b0, gg, dd, lat);
      rst_n = 1'b0;
      tick;
      n_cmp++;
      if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0 || bus.rnd_data !== '0 ||
          bus.rnd_err !== 1'b0 || bus.rng_send !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: got gnt=%b valid=%b data=%0d err=%b send=%b want all 0",
                  bus.gnt, bus.rnd_valid, bus.rnd_data, bus.rnd_err, bus.rng_send);
      end
      bus.req = '0;
      rst_n = 1'b1; exp_ptr = 0;
      tick;
   endtask

   task automatic test_random;
      logic [NREQ-1:0] gg; logic [RAND_W-1:0] dd; int lat;
      bus.req = NREQ'($urandom_range(1, 15));
      for (int it = 0; it < 30; it++) begin
         rng_q.delete();
         for (int i = 0; i <= MAX_RETRY; i++)
            rng_q.push_back(($urandom_range(0, 1) == 0) ? RAND_W'($urandom_range(1, LIMIT - 1))
                                                        : RAND_W'($urandom_range(0, 127)));
         run_txn("random", $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)), gg, dd, lat);
         bus.req = bus.req | NREQ'($urandom);
         if (bus.req == '0) bus.req = NREQ'($urandom_range(1, 15));
      end
      bus.req = '0;
      tick;
   endtask

   initial begin
      rst_n = 1'b0; bus.req = '0; bus.ack = '0;
      test_reset;
      test_single;
      test_round_robin;
      test_reject;
      test_exhaustion;
      test_abandon;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
